// File: rtl/core_seq_pkg.sv
// core_seq_pkg: shared types and instruction-bus layout for the core instruction sequencer
package core_seq_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_K_LOAD, S_K_GAP, S_X_L0, S_EXEC, S_DRAIN,
    S_A_CLR, S_A_RD, S_A_RELU, S_DONE
  } state_e;
  localparam int AW         = 11;
  localparam int I_BYPASS   = 34;
  localparam int I_ACC      = 33;
  localparam int I_CEN_P    = 32;
  localparam int I_WEN_P    = 31;
  localparam int I_AP       = 20;
  localparam int I_CEN_X    = 19;
  localparam int I_AX       = 7;
  localparam int I_OFIFO_RD = 6;
  localparam int I_L0_RD    = 3;
  localparam int I_L0_WR    = 2;
  localparam int I_EXEC     = 1;
  localparam int I_LOAD     = 0;
  localparam logic [34:0] INST_IDLE = 35'h1800C0000;
endpackage

// File: rtl/core_seq_cnt.sv
// core_seq_cnt: loadable down-counter that holds at zero and flags terminal count
//   clk_i, rst_ni (async active-low), ld_i/val_i load, en_i decrement, cnt_o value, tc_o = (cnt_o == 0)
module core_seq_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         ld_i,
  input  logic [W-1:0] val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_o <= '0;
    else if (ld_i) cnt_o <= val_i;
    else if (en_i && cnt_o != '0) cnt_o <= cnt_o - 1'b1;
  assign tc_o = cnt_o == '0;
endmodule

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: autonomous 3x3-conv tile sequencer driving the 35-bit core instruction bus
//   clk, reset (async active-low), start (pulse, taken in IDLE), ofifo_valid (core OFIFO has data)
//   inst (registered instruction), core_rst (accumulator clear pulse), kij_idx (debug),
//   busy, done (completion pulse), err (sticky drain timeout)
module core_seq_ctrl
  import core_seq_pkg::*;
#(
  parameter int          bw            = 4,
  parameter int          row           = 8,
  parameter int          col           = 8,
  parameter int          len_kij       = 9,
  parameter int          len_nij       = 36,
  parameter int          len_onij      = 16,
  parameter logic [10:0] w_base        = 11'h400,
  parameter logic [10:0] x_base        = 11'h000,
  parameter int          k_gap         = 11,
  parameter int          drain_timeout = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [34:0] inst,
  output logic        core_rst,
  output logic [3:0]  kij_idx,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int PW = 8;
  if (bw < 1 || row < 1 || col < 1 || len_kij < 1 || len_kij > 16 || len_nij < 1 ||
      len_onij < 1 || len_onij > 255 || k_gap < 1 || drain_timeout < 1 || drain_timeout > 256 ||
      row + col + len_nij > 255 || int'(w_base) + len_kij * col > 2048 ||
      int'(x_base) + len_nij > 2048 || len_kij * len_onij > 2048) begin : g_cfg_bad
    $error("core_seq_ctrl: illegal parameter combination");
  end
  state_e          state_q, state_d;
  logic [PW-1:0]   ph, ph_val, oc, o, j, wn_q, wn_d;
  logic [3:0]      kc, kij;
  logic            ph_tc, kc_tc, oc_tc, ph_ld, kc_ld, kc_en, oc_ld, oc_en;
  logic            disc_q, disc_d, err_d, wr, last_wr, xw, core_rst_d;
  logic [AW-1:0]   x_len, x_addr;
  logic [34:0]     inst_d;
  int              ph_len;
  core_seq_cnt #(.W(PW)) u_ph (
    .clk_i(clk), .rst_ni(reset), .ld_i(ph_ld), .val_i(ph_val), .en_i(1'b1), .cnt_o(ph), .tc_o(ph_tc)
  );
  core_seq_cnt #(.W(4)) u_kij (
    .clk_i(clk), .rst_ni(reset), .ld_i(kc_ld), .val_i(4'(len_kij - 1)), .en_i(kc_en), .cnt_o(kc), .tc_o(kc_tc)
  );
  core_seq_cnt #(.W(PW)) u_o (
    .clk_i(clk), .rst_ni(reset), .ld_i(oc_ld), .val_i(PW'(len_onij - 1)), .en_i(oc_en), .cnt_o(oc), .tc_o(oc_tc)
  );
  assign kij     = 4'(len_kij - 1) - kc;
  assign o       = PW'(len_onij - 1) - oc;
  assign j       = PW'(len_kij) - ph;
  // The first valid OFIFO word of every drain is a duplicate and is skipped.
  assign wr      = state_q == S_DRAIN && ofifo_valid && disc_q;
  assign last_wr = wr && wn_q == PW'(len_onij - 1);
  // W_L0 and X_L0 share one streaming pattern: the address saturates on the
  // last cycle while that cycle's read data is written into L0.
  assign xw      = state_q == S_W_L0;
  assign x_len   = xw ? AW'(col) : AW'(len_nij);
  assign x_addr  = (xw ? w_base + AW'(kij) * AW'(col) : x_base) + (ph_tc ? x_len - 1'b1 : x_len - AW'(ph));
  always_comb begin
    state_d = state_q;
    kc_ld   = 1'b0;
    kc_en   = 1'b0;
    oc_ld   = 1'b0;
    oc_en   = 1'b0;
    err_d   = err;
    wn_d    = '0;
    disc_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_W_L0;
        kc_ld   = 1'b1;
        oc_ld   = 1'b1;
        err_d   = 1'b0;
      end
      S_W_L0:   state_d = ph_tc ? S_K_LOAD : state_q;
      S_K_LOAD: state_d = ph_tc ? S_K_GAP : state_q;
      S_K_GAP:  state_d = ph_tc ? S_X_L0 : state_q;
      S_X_L0:   state_d = ph_tc ? S_EXEC : state_q;
      S_EXEC:   state_d = ph_tc ? S_DRAIN : state_q;
      S_DRAIN: begin
        wn_d   = wn_q + PW'(wr);
        disc_d = disc_q | ofifo_valid;
        if (last_wr || ph_tc) begin
          err_d   = err | !last_wr;
          state_d = kc_tc ? S_A_CLR : S_W_L0;
          kc_en   = !kc_tc;
        end
      end
      S_A_CLR: state_d = ph_tc ? S_A_RD : state_q;
      S_A_RD:  state_d = ph_tc ? S_A_RELU : state_q;
      S_A_RELU: if (ph_tc) begin
        state_d = oc_tc ? S_DONE : S_A_CLR;
        oc_en   = !oc_tc;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // Each state's length is loaded into the phase counter on entry (length - 1).
  always_comb begin
    ph_len = state_d == S_W_L0   ? col + 1 :
             state_d == S_K_LOAD ? row + col + 1 :
             state_d == S_K_GAP  ? k_gap :
             state_d == S_X_L0   ? len_nij + 1 :
             state_d == S_EXEC   ? row + col + len_nij :
             state_d == S_DRAIN  ? drain_timeout :
             state_d == S_A_RD   ? len_kij + 1 :
             (state_d == S_A_CLR || state_d == S_A_RELU) ? 2 : 1;
    ph_val = PW'(ph_len - 1);
    ph_ld  = state_d != state_q;
  end
  always_comb begin
    inst_d     = INST_IDLE;
    core_rst_d = 1'b0;
    case (state_q)
      S_W_L0, S_X_L0: begin
        inst_d[I_CEN_X]       = ph_tc;
        inst_d[I_L0_WR]       = AW'(ph) != x_len;
        inst_d[I_AX +: AW]    = x_addr;
      end
      S_K_LOAD: begin
        inst_d[I_LOAD]        = !ph_tc;
        inst_d[I_L0_RD]       = !ph_tc;
      end
      S_EXEC: begin
        inst_d[I_EXEC]        = 1'b1;
        inst_d[I_L0_RD]       = 1'b1;
      end
      S_DRAIN: begin
        inst_d[I_BYPASS]      = 1'b1;
        inst_d[I_OFIFO_RD]    = ofifo_valid;
        inst_d[I_CEN_P]       = !wr;
        inst_d[I_WEN_P]       = !wr;
        inst_d[I_AP +: AW]    = AW'(kij) * AW'(len_onij) + AW'(wn_q);
      end
      S_A_CLR: core_rst_d = !ph_tc;
      S_A_RD: begin
        inst_d[I_CEN_P]       = ph_tc;
        inst_d[I_ACC]         = ph != PW'(len_kij);
        inst_d[I_AP +: AW]    = AW'(j) * AW'(len_onij) + AW'(o);
      end
      default: inst_d = INST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q  <= S_IDLE;
      inst     <= INST_IDLE;
      core_rst <= 1'b0;
      kij_idx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      wn_q     <= '0;
      disc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      inst     <= inst_d;
      core_rst <= core_rst_d;
      kij_idx  <= state_q == S_IDLE ? 4'd0 : kij;
      busy     <= state_q != S_IDLE && state_q != S_DONE;
      done     <= state_q == S_DONE;
      err      <= err_d;
      wn_q     <= wn_d;
      disc_q   <= disc_d;
    end
endmodule

// File: tb/tb_core_seq_ctrl.sv
// tb_core_seq_ctrl: directed self-checking bench for core_seq_ctrl
module tb_core_seq_ctrl;
  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [34:0] inst;
  logic        core_rst, busy, done, err;
  logic [3:0]  kij_idx;
  int          n_cmp = 0;
  int          n_bad = 0;
  always #5 clk = ~clk;
  core_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .ofifo_valid(ofifo_valid), .inst(inst),
    .core_rst(core_rst), .kij_idx(kij_idx), .busy(busy), .done(done), .err(err)
  );
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_wl0(input int k);
    int t = 0;
    while (!(inst[19] == 1'b0 && inst[2] == 1'b0 && inst[17:7] >= 11'h400) && t < 400) begin
      tick();
      t++;
    end
    chk("wl0_found", t < 400, 1);
    chk("wl0_base", inst[17:7], 11'h400 + 11'(8 * k));
    chk("kij_idx", kij_idx, k);
    tick();
  endtask
  initial begin
    int n, t, nw, nrd, nbad, xs, nl0, r, nrst, nacc, ndone, extra;
    logic [10:0] firstx, lastx;
    logic wrt, bd;
    reset = 1'b0; start = 1'b1; ofifo_valid = 1'b0;
    repeat (3) tick();
    chk("rst_inst", inst, 35'h1800C0000);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_kij", kij_idx, 0);
    chk("rst_core_rst", core_rst, 0);
    start = 1'b0;
    tick();
    reset = 1'b1;
    repeat (4) tick();
    chk("idle_inst", inst, 35'h1800C0000);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (inst[19] && t < 10) begin tick(); t++; end
    chk("wl0_start", t < 10, 1);
    chk("busy_run", busy, 1);
    for (int i = 0; i <= 8; i++) begin
      chk("wl0_cen", inst[19], i == 8);
      chk("wl0_addr", inst[17:7], 11'h400 + 11'(i < 7 ? i : 7));
      chk("wl0_l0wr", inst[2], i != 0);
      tick();
    end
    chk("kload_l0rd", inst[3], 1);
    n = 0;
    while (inst[0] && n < 100) begin n++; tick(); end
    chk("kload_len", n, 16);
    n = 0; xs = 0; nl0 = 0; firstx = '1; lastx = '1;
    while (!inst[1] && n < 200) begin
      if (!inst[19]) begin
        if (xs == 0) firstx = inst[17:7];
        lastx = inst[17:7];
        xs++;
      end
      if (inst[2]) nl0++;
      n++;
      tick();
    end
    chk("gap_to_exec", n, 49);
    chk("x_cen_cycles", xs, 36);
    chk("x_l0wr_cycles", nl0, 36);
    chk("x_first_addr", firstx, 11'h000);
    chk("x_last_addr", lastx, 11'h023);
    chk("exec_l0rd", inst[3], 1);
    n = 0;
    while (inst[1] && n < 200) begin n++; tick(); end
    chk("exec_len", n, 52);
    chk("drain_bypass", inst[34], 1);
    chk("drain_acc", inst[33], 0);
    n = 0; nw = 0; nrd = 0; nbad = 0;
    do begin
      ofifo_valid = !(n == 1 || n == 5 || n == 9);
      tick();
      wrt = !inst[32] && !inst[31];
      if (inst[34]) begin
        if (inst[6]) nrd++;
        if (wrt && !inst[6]) nbad++;
        if (nrd == 1 && inst[6]) chk("drain_discard", wrt, 0);
        if (n == 1) chk("drain_idle", {inst[6], inst[32], inst[31]}, 3'b011);
        if (wrt) begin
          chk("drain_addr", inst[30:20], nw);
          nw++;
        end
      end
      n++;
    end while (inst[34] && n < 80);
    ofifo_valid = 1'b0;
    chk("drain_writes", nw, 16);
    chk("drain_reads", nrd, 17);
    chk("drain_stray", nbad, 0);
    wait_wl0(1);
    t = 0;
    while (!inst[34] && t < 300) begin tick(); t++; end
    chk("drain1_found", t < 300, 1);
    chk("err_pre", err, 0);
    n = 0;
    while (inst[34] && n < 200) begin n++; tick(); end
    chk("timeout_len", n, 64);
    chk("err_set", err, 1);
    ofifo_valid = 1'b1;
    for (int k = 2; k <= 8; k++) wait_wl0(k);
    t = 0;
    while (!inst[34] && t < 300) begin tick(); t++; end
    chk("drain8_found", t < 300, 1);
    n = 0; nw = 0; nrd = 0;
    while (inst[34] && n < 100) begin
      if (inst[6]) nrd++;
      if (!inst[32] && !inst[31]) begin
        chk("drain8_addr", inst[30:20], 128 + nw);
        nw++;
      end
      n++;
      tick();
    end
    chk("drain8_writes", nw, 16);
    chk("drain8_reads", nrd, 17);
    chk("drain8_len", n, 17);
    chk("err_hold", err, 1);
    n = 0; r = 0; nrst = 0; nacc = 0; ndone = 0; bd = 1'b1;
    while (ndone == 0 && n < 400) begin
      if (core_rst) nrst++;
      if (inst[33]) nacc++;
      if (!inst[32] && inst[31]) begin
        chk("acc_rd_addr", inst[30:20], (r % 9) * 16 + r / 9);
        chk("acc_flag", inst[33], r % 9 != 0);
        if (r / 9 == 5) chk("acc_bypass", inst[34], 0);
        r++;
      end
      if (done) begin ndone++; bd = busy; end
      n++;
      tick();
    end
    chk("acc_done", ndone, 1);
    chk("acc_reads", r, 144);
    chk("acc_core_rst", nrst, 16);
    chk("acc_acc_cycles", nacc, 144);
    chk("done_busy", bd, 0);
    extra = 0;
    repeat (5) begin
      if (done) extra++;
      tick();
    end
    chk("done_once", extra, 0);
    chk("post_inst", inst, 35'h1800C0000);
    chk("post_busy", busy, 0);
    chk("err_sticky", err, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_clear", err, 0);
    t = 0;
    while (!inst[1] && t < 300) begin tick(); t++; end
    chk("exec2_found", t < 300, 1);
    repeat (5) tick();
    chk("exec2_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_inst", inst, 35'h1800C0000);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_kij", kij_idx, 0);
    chk("async_rst_core_rst", core_rst, 0);
    tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("post_rst_inst", inst, 35'h1800C0000);
    chk("post_rst_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Hardware instruction sequencer that drives the core's 35-bit instruction bus, the initiator side of the core instruction interface.
- Runs a full 3x3-conv output tile autonomously: per-kij weight fetch to L0, kernel load, activation fetch, execution, OFIFO drain to PMEM, then per-output PMEM accumulation with ReLU.
- Sits between a host start/done handshake and the core, replacing stimulus sequencing.

Parameters:
- bw, 4, activation/weight bit width (informational)
- row, 8, PE array rows
- col, 8, PE array columns
- len_kij, 9, kernel positions
- len_nij, 36, input pixels per tile
- len_onij, 16, output pixels per tile
- w_base, 11'h400, XMEM base of kij0 weights; kij k at w_base + k*col
- x_base, 11'h000, XMEM base of activations
- k_gap, 11, idle cycles between kernel load and activation fetch
- drain_timeout, 64, max cycles in DRAIN without completion

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- ofifo_valid  in  1  core OFIFO has data
- inst  out  35  core instruction: [34] bypass, [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- core_rst  out  1  active-high SFU/accumulator clear pulse to core
- kij_idx  out  4  current kij (debug)
- busy  out  1  high outside IDLE/DONE
- done  out  1  one-cycle pulse at completion
- err  out  1  sticky drain timeout; cleared on next accepted start

Behaviour:
- All outputs registered. Reset value: inst = 35'h1800C0000 (both CEN/WEN = 1, all else 0), core_rst=0, kij_idx=0, busy=0, done=0, err=0.
- Asserting reset mid-operation returns to IDLE immediately; inst returns to its reset value.
- States: IDLE -> W_L0 -> K_LOAD -> K_GAP -> X_L0 -> EXEC -> DRAIN -> (kij<len_kij-1 ? W_L0 with kij+1 : A_CLR) -> A_RD -> A_RELU -> (o<len_onij-1 ? A_CLR with o+1 : DONE) -> IDLE.
- W_L0, col+1 cycles:
  - Cycle 0: CEN_xmem=0, WEN_xmem=1, A_xmem = w_base + kij*col, l0_wr=0.
  - Cycles 1..col: l0_wr=1, A_xmem increments while < base+col-1.
  - Exit cycle: CEN_xmem=1, l0_wr=0.
- K_LOAD: row+col cycles, load=1 and l0_rd=1; then 1 cycle with both 0.
- K_GAP: k_gap cycles, all strobes idle.
- X_L0: len_nij+1 cycles, same pattern as W_L0 from x_base. CEN_xmem=1 on the final address cycle.
- EXEC: row+col+len_nij cycles, execute=1 and l0_rd=1.
- DRAIN:
  - bypass=1, acc=0.
  - ofifo_rd = ofifo_valid.
  - The first valid read is discarded (duplicate); no PMEM write.
  - Each subsequent valid read sets CEN_pmem=0, WEN_pmem=0, A_pmem = kij*len_onij + n for n = 0..len_onij-1.
  - Cycles with ofifo_valid=0: ofifo_rd=0, CEN_pmem=WEN_pmem=1.
  - Exit after len_onij writes.
  - If drain_timeout cycles elapse first: set err and proceed to the next state anyway.
- A_CLR: 1 cycle core_rst=1, then 1 cycle core_rst=0.
- A_RD: len_kij+1 cycles.
  - Cycles j < len_kij: CEN_pmem=0, WEN_pmem=1, A_pmem = j*len_onij + o, bypass=0.
  - Cycle j = len_kij: CEN_pmem=1.
  - acc=1 for j >= 1.
- A_RELU: 2 cycles, acc=0.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- start outside IDLE is ignored. ififo_wr and ififo_rd are always 0.
- Address arithmetic is 11-bit unsigned. Parameter combinations exceeding 2047 are illegal; an elaboration-time check is required.

Decomposition:
- Package core_seq_pkg: state enum, inst bit-position localparams, INST_IDLE = 35'h1800C0000.
- Sub-module core_seq_cnt: loadable down-counter with terminal-count flag, reused for phase length, kij, and output-pixel counters.

Test Plan:
- Reset with start held high -> inst=35'h1800C0000, busy=0; no state change until reset is released and a fresh start arrives.
- start, kij=0 -> W_L0 A_xmem sequence 0x400..0x407 with l0_wr high 8 cycles; K_LOAD load=1 for exactly 16 cycles; EXEC execute=1 for exactly 52 cycles.
- DRAIN with ofifo_valid toggling 1,0,1,1,... -> first read has no write; PMEM writes land at 0..15 for kij 0 and 128..143 for kij 8, with no write on invalid cycles.
- ofifo_valid tied 0 in DRAIN -> err=1 after 64 cycles; sequence continues; next start clears err.
- Accumulation o=5 -> core_rst pulse, then A_pmem reads 5,21,37,...,133 with acc high from the second read; done pulses once after o=15.
- Reset asserted during EXEC -> inst returns to its reset value the same cycle asynchronously; busy=0; kij_idx=0.
